// File: rtl/spi_slave_regfile.sv
// SPI slave fronting a NUM_REGS x DATA_W register file; all logic in the clk domain.
// Frame: 8-bit command (bit7 = write, bits[6:0] = address) then DATA_W data bits, MSB first.
module spi_slave_regfile #(
    parameter int                DATA_W    = 16,
    parameter int                NUM_REGS  = 4,
    parameter logic              CPOL      = 1'b0,
    parameter logic              CPHA      = 1'b0,
    parameter logic [DATA_W-1:0] RESET_VAL = '0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              spi_sclk_in,
    input  logic              spi_mosi_in,
    input  logic              spi_cs_n_in,
    output logic              spi_miso_out,
    output logic [DATA_W-1:0] led,
    output logic              wr_pulse,
    output logic [6:0]        wr_addr,
    output logic [DATA_W-1:0] wr_data,
    output logic              frame_err
);

    localparam int CNT_W = 6;
    localparam int IDX_W = $clog2(DATA_W);
    localparam logic [CNT_W-1:0] CMD_LAST  = CNT_W'(7);
    localparam logic [CNT_W-1:0] DATA_LAST = CNT_W'(DATA_W - 1);

    typedef enum logic [1:0] {IDLE, CMD, DATA, DONE} state_e;

    state_e                          state_q, state_d;
    logic                            sclk_s1_q, sclk_s2_q, sclk_prev_q;
    logic                            sclk_s1_d, sclk_s2_d, sclk_prev_d;
    logic                            cs_s1_q, cs_s2_q, cs_prev_q;
    logic                            cs_s1_d, cs_s2_d, cs_prev_d;
    logic                            mosi_s1_q, mosi_s2_q, mosi_s1_d, mosi_s2_d;
    logic [1:0]                      vld_q, vld_d;
    logic                            armed_q, armed_d;
    logic [CNT_W-1:0]                bit_cnt_q, bit_cnt_d;
    logic [6:0]                      cmd_q, cmd_d;
    logic                            is_wr_q, is_wr_d;
    logic [6:0]                      addr_q, addr_d;
    logic [DATA_W-2:0]               rx_q, rx_d;
    logic [DATA_W-1:0]               snap_q, snap_d;
    logic                            miso_q, miso_d;
    logic [NUM_REGS-1:0][DATA_W-1:0] regs_q, regs_d;
    logic                            wr_pulse_q, wr_pulse_d;
    logic [6:0]                      wr_addr_q, wr_addr_d;
    logic [DATA_W-1:0]               wr_data_q, wr_data_d;
    logic                            frame_err_q, frame_err_d;

    logic              lead_edge, trail_edge, sample_edge, shift_edge;
    logic              cs_fall, cs_rise, wr_hit;
    logic [7:0]        cmd_next;
    logic [DATA_W-1:0] rx_next, rd_val;
    logic [IDX_W-1:0]  tx_idx;

    always_comb begin
        state_d     = state_q;
        sclk_s1_d   = spi_sclk_in;
        sclk_s2_d   = sclk_s1_q;
        sclk_prev_d = sclk_s2_q;
        cs_s1_d     = spi_cs_n_in;
        cs_s2_d     = cs_s1_q;
        cs_prev_d   = cs_s2_q;
        mosi_s1_d   = spi_mosi_in;
        mosi_s2_d   = mosi_s1_q;
        vld_d       = {vld_q[0], 1'b1};
        armed_d     = armed_q;
        bit_cnt_d   = bit_cnt_q;
        cmd_d       = cmd_q;
        is_wr_d     = is_wr_q;
        addr_d      = addr_q;
        rx_d        = rx_q;
        snap_d      = snap_q;
        miso_d      = miso_q;
        regs_d      = regs_q;
        wr_pulse_d  = 1'b0;
        wr_addr_d   = wr_addr_q;
        wr_data_d   = wr_data_q;
        frame_err_d = 1'b0;

        lead_edge   = (sclk_prev_q == CPOL) && (sclk_s2_q != CPOL);
        trail_edge  = (sclk_prev_q != CPOL) && (sclk_s2_q == CPOL);
        sample_edge = CPHA ? trail_edge : lead_edge;
        shift_edge  = CPHA ? lead_edge : trail_edge;
        cs_fall     = cs_prev_q && !cs_s2_q;
        cs_rise     = !cs_prev_q && cs_s2_q;
        cmd_next    = {cmd_q, mosi_s2_q};
        rx_next     = {rx_q, mosi_s2_q};
        // bit_cnt counts data bits already sampled, which is also the index of the next bit to send
        tx_idx      = IDX_W'(DATA_W - 1) - IDX_W'(bit_cnt_q);

        rd_val = '0;
        wr_hit = 1'b0;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (cmd_next[6:0] == 7'(i)) rd_val = regs_q[i];
            if (addr_q == 7'(i)) wr_hit = 1'b1;
        end

        // The synchronizers only hold real pin levels two clocks after reset; a frame
        // already running then must not look like a fresh cs_n falling edge.
        if (vld_q[1] && cs_s2_q) armed_d = 1'b1;

        case (state_q)
            IDLE: begin
                miso_d = 1'b0;
                if (armed_q && cs_fall) begin
                    state_d   = CMD;
                    bit_cnt_d = '0;
                end
            end
            CMD: begin
                miso_d = 1'b0;
                if (cs_rise) begin
                    frame_err_d = 1'b1;
                    state_d     = IDLE;
                end else if (sample_edge) begin
                    cmd_d = cmd_next[6:0];
                    if (bit_cnt_q == CMD_LAST) begin
                        is_wr_d   = cmd_next[7];
                        addr_d    = cmd_next[6:0];
                        snap_d    = cmd_next[7] ? '0 : rd_val;
                        bit_cnt_d = '0;
                        state_d   = DATA;
                        if (!CPHA && !cmd_next[7]) miso_d = rd_val[DATA_W-1];
                    end else begin
                        bit_cnt_d = bit_cnt_q + 1'b1;
                    end
                end
            end
            DATA: begin
                if (cs_rise) begin
                    frame_err_d = 1'b1;
                    miso_d      = 1'b0;
                    state_d     = IDLE;
                end else if (shift_edge) begin
                    miso_d = snap_q[tx_idx];
                end else if (sample_edge) begin
                    rx_d = rx_next[DATA_W-2:0];
                    if (bit_cnt_q == DATA_LAST) begin
                        miso_d  = 1'b0;
                        state_d = DONE;
                        if (is_wr_q && wr_hit) begin
                            for (int i = 0; i < NUM_REGS; i++) begin
                                if (addr_q == 7'(i)) regs_d[i] = rx_next;
                            end
                            wr_pulse_d = 1'b1;
                            wr_addr_d  = addr_q;
                            wr_data_d  = rx_next;
                        end
                    end else begin
                        bit_cnt_d = bit_cnt_q + 1'b1;
                    end
                end
            end
            DONE: begin
                miso_d    = 1'b0;
                bit_cnt_d = '0;
                if (cs_rise) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            sclk_s1_q   <= CPOL;
            sclk_s2_q   <= CPOL;
            sclk_prev_q <= CPOL;
            cs_s1_q     <= 1'b1;
            cs_s2_q     <= 1'b1;
            cs_prev_q   <= 1'b1;
            mosi_s1_q   <= 1'b0;
            mosi_s2_q   <= 1'b0;
            vld_q       <= '0;
            armed_q     <= 1'b0;
            bit_cnt_q   <= '0;
            cmd_q       <= '0;
            is_wr_q     <= 1'b0;
            addr_q      <= '0;
            rx_q        <= '0;
            snap_q      <= '0;
            miso_q      <= 1'b0;
            regs_q      <= {NUM_REGS{RESET_VAL}};
            wr_pulse_q  <= 1'b0;
            wr_addr_q   <= '0;
            wr_data_q   <= '0;
            frame_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            sclk_s1_q   <= sclk_s1_d;
            sclk_s2_q   <= sclk_s2_d;
            sclk_prev_q <= sclk_prev_d;
            cs_s1_q     <= cs_s1_d;
            cs_s2_q     <= cs_s2_d;
            cs_prev_q   <= cs_prev_d;
            mosi_s1_q   <= mosi_s1_d;
            mosi_s2_q   <= mosi_s2_d;
            vld_q       <= vld_d;
            armed_q     <= armed_d;
            bit_cnt_q   <= bit_cnt_d;
            cmd_q       <= cmd_d;
            is_wr_q     <= is_wr_d;
            addr_q      <= addr_d;
            rx_q        <= rx_d;
            snap_q      <= snap_d;
            miso_q      <= miso_d;
            regs_q      <= regs_d;
            wr_pulse_q  <= wr_pulse_d;
            wr_addr_q   <= wr_addr_d;
            wr_data_q   <= wr_data_d;
            frame_err_q <= frame_err_d;
        end
    end

    // Gate with the raw pin so MISO drops as soon as the master releases cs_n.
    assign spi_miso_out = miso_q & ~spi_cs_n_in;
    assign led          = regs_q[0];
    assign wr_pulse     = wr_pulse_q;
    assign wr_addr      = wr_addr_q;
    assign wr_data      = wr_data_q;
    assign frame_err    = frame_err_q;

endmodule

// File: tb/tb_spi_slave_regfile.sv
// Bench for spi_slave_regfile: one instance per SPI mode, directed plus random frames
// checked against a plain array model of each register file.
module tb_spi_slave_regfile;

    logic                  clk = 1'b0;
    logic                  rst = 1'b1;
    logic [3:0]            sclk = 4'b1100;
    logic [3:0]            cs_n = 4'hF;
    logic                  mosi = 1'b0;
    logic [3:0]            miso;
    logic [3:0][15:0]      led;
    logic [3:0]            wr_pulse;
    logic [3:0][6:0]       wr_addr;
    logic [3:0][15:0]      wr_data;
    logic [3:0]            frame_err;

    int                    tests = 0;
    int                    fails = 0;
    int                    wp_cnt [4];
    int                    fe_cnt [4];
    logic [6:0]            pulse_addr [4];
    logic [15:0]           pulse_data [4];
    logic [15:0]           mdl [4][4];

    always #5 clk = ~clk;

    for (genvar g = 0; g < 4; g++) begin : g_dut
        spi_slave_regfile #(
            .DATA_W(16), .NUM_REGS(4), .CPOL(1'(g >> 1)), .CPHA(1'(g & 1)), .RESET_VAL(16'h0)
        ) u_dut (
            .clk(clk), .rst(rst), .spi_sclk_in(sclk[g]), .spi_mosi_in(mosi),
            .spi_cs_n_in(cs_n[g]), .spi_miso_out(miso[g]), .led(led[g]),
            .wr_pulse(wr_pulse[g]), .wr_addr(wr_addr[g]), .wr_data(wr_data[g]),
            .frame_err(frame_err[g])
        );
    end

    always @(negedge clk) begin
        for (int m = 0; m < 4; m++) begin
            if (wr_pulse[m]) begin
                wp_cnt[m]     <= wp_cnt[m] + 1;
                pulse_addr[m] <= wr_addr[m];
                pulse_data[m] <= wr_data[m];
            end
            if (frame_err[m]) fe_cnt[m] <= fe_cnt[m] + 1;
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic half();
        repeat (8) @(negedge clk);
    endtask

    // Master side of one frame; nbits < 16 aborts early, rst_bit >= 0 pulses rst before that bit.
    task automatic xfer(input logic [1:0] m, input logic [7:0] cmd, input logic [15:0] data,
                        input int nbits, input int rst_bit,
                        output logic [15:0] rd, output logic cmd_miso);
        logic [23:0] fr;
        logic        cpol, cpha;
        fr = {cmd, data};
        cpol = m[1];
        cpha = m[0];
        rd = '0;
        cmd_miso = 1'b0;
        cs_n[m] = 1'b0;
        half();
        for (int i = 0; i < 8 + nbits; i++) begin
            if (i == rst_bit) begin
                rst = 1'b1;
                @(negedge clk);
                rst = 1'b0;
            end
            if (!cpha) begin
                mosi = fr[23-i];
                half();
                if (i >= 8) rd[23-i] = miso[m]; else cmd_miso |= miso[m];
                sclk[m] = ~cpol;
                half();
                sclk[m] = cpol;
            end else begin
                sclk[m] = ~cpol;
                mosi = fr[23-i];
                half();
                if (i >= 8) rd[23-i] = miso[m]; else cmd_miso |= miso[m];
                sclk[m] = cpol;
                half();
            end
        end
        half();
        cs_n[m] = 1'b1;
        half();
    endtask

    task automatic do_wr(input logic [1:0] m, input logic [6:0] a, input logic [15:0] d);
        int          wp0;
        logic [15:0] rd;
        logic        cm;
        wp0 = wp_cnt[m];
        xfer(m, {1'b1, a}, d, 16, -1, rd, cm);
        if (a < 7'd4) begin
            mdl[m][a[1:0]] = d;
            check("wr_pulse_count", 32'(wp_cnt[m] - wp0), 32'd1);
            check("wr_addr_at_pulse", 32'(pulse_addr[m]), 32'(a));
            check("wr_data_at_pulse", 32'(pulse_data[m]), 32'(d));
        end else begin
            check("wr_dropped_no_pulse", 32'(wp_cnt[m] - wp0), 32'd0);
        end
        check("led_mirror", 32'(led[m]), 32'(mdl[m][0]));
    endtask

    task automatic do_rd(input logic [1:0] m, input logic [6:0] a);
        int          wp0;
        logic [15:0] rd, exp;
        logic        cm;
        wp0 = wp_cnt[m];
        exp = (a < 7'd4) ? mdl[m][a[1:0]] : 16'h0;
        xfer(m, {1'b0, a}, 16'($urandom), 16, -1, rd, cm);
        check("read_data", 32'(rd), 32'(exp));
        check("miso_low_in_cmd", 32'(cm), 32'd0);
        check("read_no_pulse", 32'(wp_cnt[m] - wp0), 32'd0);
    endtask

    initial begin
        logic [15:0] rd;
        logic        cm;
        int          wp0, fe0;
        for (int m = 0; m < 4; m++) for (int a = 0; a < 4; a++) mdl[m][a] = 16'h0;

        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        for (int m = 0; m < 4; m++) begin
            check("rst_led", 32'(led[m]), 32'd0);
            check("rst_wr_pulse", 32'(wr_pulse[m]), 32'd0);
            check("rst_frame_err", 32'(frame_err[m]), 32'd0);
            check("rst_miso", 32'(miso[m]), 32'd0);
            check("rst_wr_addr", 32'(wr_addr[m]), 32'd0);
            check("rst_wr_data", 32'(wr_data[m]), 32'd0);
        end
        repeat (4) @(negedge clk);

        // Mode 0 basic write / readback
        do_wr(2'd0, 7'd1, 16'hA5C3);
        check("wr_addr_hold", 32'(wr_addr[0]), 32'd1);
        check("wr_data_hold", 32'(wr_data[0]), 32'hA5C3);
        do_wr(2'd0, 7'd0, 16'h1234);
        do_rd(2'd0, 7'd0);

        // Every mode: write and read back register 2
        for (int m = 0; m < 4; m++) begin
            do_wr(2'(m), 7'd2, 16'hBEEF);
            do_rd(2'(m), 7'd2);
        end

        // Out-of-range address
        do_wr(2'd0, 7'd5, 16'hFFFF);
        do_rd(2'd0, 7'd5);
        for (int a = 0; a < 4; a++) do_rd(2'd0, 7'(a));

        // Aborted write after 10 data bits
        wp0 = wp_cnt[0];
        fe0 = fe_cnt[0];
        xfer(2'd0, 8'h80, 16'hDEAD, 10, -1, rd, cm);
        check("abort_frame_err", 32'(fe_cnt[0] - fe0), 32'd1);
        check("abort_no_pulse", 32'(wp_cnt[0] - wp0), 32'd0);
        check("abort_led", 32'(led[0]), 32'(mdl[0][0]));
        check("abort_miso_low", 32'(miso[0]), 32'd0);
        do_wr(2'd0, 7'd0, 16'h5A5A);

        // Random traffic over all modes
        for (int n = 0; n < 40; n++) begin
            logic [1:0]  m;
            logic [6:0]  a;
            m = 2'($urandom_range(0, 3));
            a = 7'($urandom_range(0, 7));
            if ($urandom_range(0, 1) == 1) do_wr(m, a, 16'($urandom));
            else do_rd(m, a);
        end

        // Reset mid-data of a write
        do_wr(2'd0, 7'd1, 16'h5555);
        do_wr(2'd3, 7'd0, 16'h7777);
        wp0 = wp_cnt[0];
        fe0 = fe_cnt[0];
        xfer(2'd0, 8'h80, 16'h00FF, 16, 12, rd, cm);
        check("rst_mid_no_pulse", 32'(wp_cnt[0] - wp0), 32'd0);
        check("rst_mid_no_err", 32'(fe_cnt[0] - fe0), 32'd0);
        for (int m = 0; m < 4; m++) begin
            for (int a = 0; a < 4; a++) mdl[m][a] = 16'h0;
            check("rst_mid_led", 32'(led[m]), 32'd0);
        end
        do_rd(2'd0, 7'd1);
        do_rd(2'd3, 7'd0);
        do_wr(2'd0, 7'd0, 16'h00FF);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
